multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the datapath word width; it is carried for consistency and is unused internally.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port op, input, `OP (6 bits): opcode field from decoder.
REQ-005 The block SHALL have port funct, input, `FUNCT (6 bits): funct field from decoder.
REQ-006 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: memory completes the current request this cycle.
REQ-008 The block SHALL have port state, output, 3 bits: current FSM state.
REQ-009 The block SHALL have the following 1-bit outputs: pc_we, ir_we, iord (0=PC addr, 1=ALU addr), reg_we, reg_dst (1=rd, 0=rt), mem_to_reg, mem_req, mem_we, halted, illegal.
REQ-010 The block SHALL have port pc_src, output, 2 bits: 0=PC+4, 1=branch target, 2=jump target.
REQ-011 The block SHALL have port alu_src_b, output, 2 bits: 0=rt, 1=imm16 sign-extended, 2=constant 4.
REQ-012 The block SHALL have port alu_op, output, 4 bits: ALU operation code.

Function
REQ-013 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 All outputs SHALL be combinational from the state, the latched op/funct and the inputs; every enable not listed for a state is 0.
REQ-015 FETCH SHALL assert mem_req=1 and iord=0, and SHALL hold while mem_ready=0.
REQ-016 In FETCH with mem_ready=1, the block SHALL assert ir_we=1, pc_we=1 and pc_src=0, and go to DECODE.
REQ-017 DECODE SHALL last one cycle and SHALL latch op/funct into internal registers used by all later states of this instruction.
REQ-018 From DECODE, R-type (op 0x00) with funct in {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt} SHALL go to EXEC.
REQ-019 From DECODE, ops 0x08 addi, 0x23 lw, 0x2B sw and 0x04 beq SHALL go to EXEC.
REQ-020 From DECODE, op 0x02 (j) SHALL assert pc_we=1 and pc_src=2, and go to FETCH.
REQ-021 From DECODE, R-type funct 0x0C (syscall) SHALL go to HALT.
REQ-022 From DECODE, any other op/funct SHALL pulse illegal=1 for one cycle and go to FETCH, i.e. be treated as a nop.
REQ-023 EXEC SHALL drive alu_op per the alu_control mapping.
REQ-024 In EXEC, alu_src_b SHALL be 1 for addi/lw/sw and 0 otherwise.
REQ-025 In EXEC, beq SHALL assert pc_we=zero and pc_src=1, then go to FETCH.
REQ-026 In EXEC, R-type and addi SHALL go to WB, and lw/sw SHALL go to MEM.
REQ-027 MEM SHALL assert mem_req=1, iord=1, and mem_we=1 for sw only, and SHALL hold while mem_ready=0.
REQ-028 In MEM with mem_ready=1, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-029 WB SHALL assert reg_we=1, with reg_dst=1 for R-type and 0 otherwise, and mem_to_reg=1 for lw only, then go to FETCH.
REQ-030 HALT SHALL assert halted=1 and drive all enables to 0, and SHALL be left only by reset.
REQ-031 Latency with zero memory wait (mem_ready=1 on first request cycle) SHALL be: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 2.
REQ-032 Each mem_ready wait cycle SHALL add exactly one cycle to the latency in REQ-031.
REQ-033 mem_ready asserted outside FETCH/MEM SHALL be ignored.
REQ-034 pc_we and ir_we SHALL never be asserted in the same cycle as reg_we or mem_we.

Reset
REQ-035 With rst_n=0 at a rising clk edge, the state SHALL become FETCH and the latched op/funct SHALL clear to 0.
REQ-036 While rst_n=0, all enables, illegal and halted SHALL be 0.
REQ-037 Reset asserted mid-instruction (including during a MEM wait) SHALL abandon the instruction, with no further write enables after that edge.

Structure
REQ-038 State encodings, opcode/funct constants and alu_op codes SHALL live in defines.vh alongside the existing field macros.
REQ-039 The op/funct-to-alu_op mapping SHALL be a separate combinational sub-module, alu_control.

Verification
REQ-040 Reset then add (op 0x00, funct 0x20) with mem_ready=1 SHALL give states FETCH, DECODE, EXEC, WB, FETCH, with reg_we=1 and reg_dst=1 only in WB.
REQ-041 lw (0x23) with mem_ready held low for 3 MEM cycles SHALL stay in MEM for 4 cycles with iord=1 and mem_we=0, then WB with mem_to_reg=1, for 8 cycles total.
REQ-042 beq (0x04) SHALL produce pc_we=1 and pc_src=1 in EXEC when zero=1, and pc_we=0 when zero=0; both cases SHALL return to FETCH.
REQ-043 j (0x02) SHALL produce pc_we=1 and pc_src=2 in DECODE; op 0x3F SHALL produce a one-cycle illegal=1 and no write enables.
REQ-044 syscall SHALL produce halted=1 held for at least 10 cycles with all enables 0; rst_n=0 for one edge SHALL return the block to FETCH.
REQ-045 rst_n=0 during a sw MEM wait SHALL give mem_we=0 from the next cycle and state FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// field constants, datapath select codes and ALU operation codes.
package multicycle_ctrl_pkg;

    localparam int OP_W     = 6;
    localparam int FUNCT_W  = 6;
    localparam int ALU_OP_W = 4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_SYSCALL = 6'h0C;
    localparam logic [FUNCT_W-1:0] FN_ADD     = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB     = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND     = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR      = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT     = 6'h2A;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;

    function automatic logic is_rtype_alu(input logic [FUNCT_W-1:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_control.sv
// Combinational op/funct to ALU operation mapping. Address arithmetic for
// loads/stores and addi uses ADD; beq compares by subtraction.
module alu_control
    import multicycle_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALU_OP_W-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else if (op == OP_BEQ) begin
            alu_op = ALU_SUB;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch, decode, execute, memory and
// write-back, producing datapath enables and selects each cycle.
//
// state  | meaning
// FETCH  | instruction read at PC; holds until mem_ready, then IR/PC update
// DECODE | op/funct latched; jumps resolve here, illegal ops become nops
// EXEC   | ALU operation; beq resolves here
// MEM    | data read/write at ALU address; holds until mem_ready
// WB     | register file write
// HALT   | syscall reached; only reset leaves
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [2:0]          state,
    output logic                pc_we,
    output logic                ir_we,
    output logic                iord,
    output logic                reg_we,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                mem_req,
    output logic                mem_we,
    output logic                halted,
    output logic                illegal,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op
);

    if (DATA_WIDTH < 1) begin : g_data_width_invalid
    end

    state_t               state_q, state_d;
    logic [OP_W-1:0]      op_q;
    logic [FUNCT_W-1:0]   funct_q;
    logic [ALU_OP_W-1:0]  exec_alu_op;

    alu_control u_alu_control (
        .op     (op_q),
        .funct  (funct_q),
        .alu_op (exec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        pc_src     = PC_SRC_SEQ;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;

        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            // Decode steers from the live op/funct; the latched copy is
            // only valid from the following state onward.
            ST_DECODE: begin
                if (op == OP_RTYPE) begin
                    if (is_rtype_alu(funct)) begin
                        state_d = ST_EXEC;
                    end else if (funct == FN_SYSCALL) begin
                        state_d = ST_HALT;
                    end else begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    case (op)
                        OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = ST_EXEC;
                        OP_J: begin
                            pc_we   = 1'b1;
                            pc_src  = PC_SRC_JUMP;
                            state_d = ST_FETCH;
                        end
                        default: begin
                            illegal = 1'b1;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                alu_op = exec_alu_op;
                if (op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW) begin
                    alu_src_b = SRCB_IMM;
                end
                case (op_q)
                    OP_BEQ: begin
                        pc_we   = zero;
                        pc_src  = PC_SRC_BRANCH;
                        state_d = ST_FETCH;
                    end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op_q == OP_SW);
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (op_q == OP_RTYPE);
                mem_to_reg = (op_q == OP_LW);
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset is synchronous, so mask side effects while it is held.
        if (!rst_n) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            halted  = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares state and control outputs against hand-derived values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] state;
    logic       pc_we, ir_we, iord, reg_we, reg_dst, mem_to_reg;
    logic       mem_req, mem_we, halted, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .state      (state),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .iord       (iord),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .halted     (halted),
        .illegal    (illegal),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // en = {pc_we, ir_we, reg_we, mem_we}
    task automatic cyc(input string tag, input logic [2:0] st, input logic [3:0] en);
        #1;
        chk({tag, "_state"}, {5'd0, state}, {5'd0, st});
        chk({tag, "_en"}, {4'd0, pc_we, ir_we, reg_we, mem_we}, {4'd0, en});
    endtask

    logic [5:0] v_op    [5] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
    logic [5:0] v_funct [5] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    logic [3:0] v_alu   [5] = '{4'd6, 4'd0, 4'd1, 4'd7, 4'd2};
    logic [1:0] v_srcb  [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic       v_rdst  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        tick();
        tick();
        cyc("rst_hold", 3'd0, 4'b0000);
        chk("rst_mem_req", {7'd0, mem_req}, 8'd0);
        chk("rst_halted", {7'd0, halted}, 8'd0);

        // add with zero wait; op is scrambled after decode to prove latching
        rst_n = 1'b1; op = 6'h00; funct = 6'h20; mem_ready = 1'b1;
        cyc("add_f", 3'd0, 4'b1100);
        chk("add_f_memreq", {7'd0, mem_req}, 8'd1);
        chk("add_f_iord", {7'd0, iord}, 8'd0);
        chk("add_f_pcsrc", {6'd0, pc_src}, 8'd0);
        tick();
        cyc("add_d", 3'd1, 4'b0000);
        chk("add_d_illegal", {7'd0, illegal}, 8'd0);
        tick();
        op = 6'h3F; funct = 6'h3F;
        cyc("add_e", 3'd2, 4'b0000);
        chk("add_e_aluop", {4'd0, alu_op}, 8'd2);
        chk("add_e_srcb", {6'd0, alu_src_b}, 8'd0);
        tick();
        cyc("add_wb", 3'd4, 4'b0010);
        chk("add_wb_rdst", {7'd0, reg_dst}, 8'd1);
        chk("add_wb_m2r", {7'd0, mem_to_reg}, 8'd0);
        tick();
        cyc("add_done", 3'd0, 4'b1100);

        // remaining R-type ops and addi
        for (int i = 0; i < 5; i++) begin
            op = v_op[i]; funct = v_funct[i]; mem_ready = 1'b1;
            cyc("alu_f", 3'd0, 4'b1100);
            tick();
            cyc("alu_d", 3'd1, 4'b0000);
            tick();
            cyc("alu_e", 3'd2, 4'b0000);
            chk("alu_e_aluop", {4'd0, alu_op}, {4'd0, v_alu[i]});
            chk("alu_e_srcb", {6'd0, alu_src_b}, {6'd0, v_srcb[i]});
            tick();
            cyc("alu_wb", 3'd4, 4'b0010);
            chk("alu_wb_rdst", {7'd0, reg_dst}, {7'd0, v_rdst[i]});
            tick();
        end

        // lw with one fetch wait cycle, then three MEM wait cycles
        op = 6'h23; funct = 6'h00; mem_ready = 1'b0;
        cyc("lw_fwait", 3'd0, 4'b0000);
        chk("lw_fwait_memreq", {7'd0, mem_req}, 8'd1);
        tick();
        mem_ready = 1'b1;
        cyc("lw_f", 3'd0, 4'b1100);
        tick();
        cyc("lw_d", 3'd1, 4'b0000);
        tick();
        mem_ready = 1'b0;
        cyc("lw_e", 3'd2, 4'b0000);
        chk("lw_e_srcb", {6'd0, alu_src_b}, 8'd1);
        chk("lw_e_aluop", {4'd0, alu_op}, 8'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ready = 1'b1;
            cyc("lw_mem", 3'd3, 4'b0000);
            chk("lw_mem_iord", {7'd0, iord}, 8'd1);
            chk("lw_mem_req", {7'd0, mem_req}, 8'd1);
        end
        tick();
        cyc("lw_wb", 3'd4, 4'b0010);
        chk("lw_wb_m2r", {7'd0, mem_to_reg}, 8'd1);
        chk("lw_wb_rdst", {7'd0, reg_dst}, 8'd0);
        tick();
        cyc("lw_done", 3'd0, 4'b1100);

        // beq taken then not taken
        op = 6'h04; zero = 1'b1;
        tick();
        cyc("beq1_d", 3'd1, 4'b0000);
        tick();
        cyc("beq1_e", 3'd2, 4'b1000);
        chk("beq1_pcsrc", {6'd0, pc_src}, 8'd1);
        chk("beq1_aluop", {4'd0, alu_op}, 8'd6);
        tick();
        cyc("beq1_done", 3'd0, 4'b1100);
        zero = 1'b0;
        tick();
        tick();
        cyc("beq0_e", 3'd2, 4'b0000);
        tick();
        cyc("beq0_done", 3'd0, 4'b1100);

        // j resolves in decode
        op = 6'h02;
        tick();
        cyc("j_d", 3'd1, 4'b1000);
        chk("j_pcsrc", {6'd0, pc_src}, 8'd2);
        tick();
        cyc("j_done", 3'd0, 4'b1100);

        // illegal op and illegal R-type funct become nops
        op = 6'h3F;
        tick();
        cyc("ill_d", 3'd1, 4'b0000);
        chk("ill_flag", {7'd0, illegal}, 8'd1);
        chk("ill_memreq", {7'd0, mem_req}, 8'd0);
        tick();
        cyc("ill_done", 3'd0, 4'b1100);
        chk("ill_clear", {7'd0, illegal}, 8'd0);
        op = 6'h00; funct = 6'h21;
        tick();
        cyc("illf_d", 3'd1, 4'b0000);
        chk("illf_flag", {7'd0, illegal}, 8'd1);
        tick();

        // sw: reset lands during a MEM wait
        op = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
        cyc("sw_f", 3'd0, 4'b1100);
        tick();
        tick();
        mem_ready = 1'b0;
        cyc("sw_e", 3'd2, 4'b0000);
        chk("sw_e_srcb", {6'd0, alu_src_b}, 8'd1);
        tick();
        cyc("sw_mem", 3'd3, 4'b0001);
        tick();
        cyc("sw_memwait", 3'd3, 4'b0001);
        rst_n = 1'b0;
        cyc("sw_rst_now", 3'd3, 4'b0000);
        tick();
        cyc("sw_rst_after", 3'd0, 4'b0000);
        rst_n = 1'b1; mem_ready = 1'b1;
        cyc("sw_restart", 3'd0, 4'b1100);

        // syscall halts until reset
        op = 6'h00; funct = 6'h0C;
        tick();
        cyc("sys_d", 3'd1, 4'b0000);
        tick();
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            cyc("halt", 3'd5, 4'b0000);
            chk("halt_flag", {7'd0, halted}, 8'd1);
            chk("halt_memreq", {7'd0, mem_req}, 8'd0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_ready = 1'b1;
        cyc("halt_exit", 3'd0, 4'b1100);
        chk("halt_exit_flag", {7'd0, halted}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
